// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment scan controller and its helpers.
package seg_display_pkg;

  localparam int DIGIT_W = 3;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_slot_timer.sv
// Slot counter and digit index for the scan; emits end-of-blank, end-of-slot and end-of-frame strobes.
module scan_slot_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int IDX_W        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [IDX_W-1:0] idx,
  output logic             blank_end,
  output logic             slot_end,
  output logic             frame_end
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;

  assign blank_end = !clear && (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign slot_end  = !clear && (cnt == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  // Clearing holds both the counter and the index at zero, so a restart always begins at digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (clear) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= frame_end ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// 3-bit digit code to active-low segment pattern {g,f,e,d,c,b,a}.
module seven_segment_decoder
  import seg_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (code)
      3'd0:    seg_n = 7'b1000000;
      3'd1:    seg_n = 7'b1111001;
      3'd2:    seg_n = 7'b0100100;
      3'd3:    seg_n = 7'b0110000;
      3'd4:    seg_n = 7'b0011001;
      3'd5:    seg_n = 7'b0010010;
      3'd6:    seg_n = 7'b0000010;
      3'd7:    seg_n = 7'b1111000;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed scan controller: frame buffer with tear-free commit, blank-then-show slots, registered strobes.
module seven_segment_scan_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          load_valid,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
  output logic                          load_ready,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [6:0]                    seg_n,
  output logic                          frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BUF_W = DIGIT_W * NUM_DIGITS;
  localparam logic [NUM_DIGITS-1:0] AN_LSB = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  scan_state_t state, state_d;
  logic [IDX_W-1:0]   idx;
  logic               clear, blank_end, slot_end, frame_end;
  logic [BUF_W-1:0]   active, pending;
  logic               pend_full;
  logic [DIGIT_W-1:0] cur_code;
  logic [6:0]         cur_seg;
  logic               lit;

  assign clear = !enable || (state == OFF);

  scan_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .idx      (idx),
    .blank_end(blank_end),
    .slot_end (slot_end),
    .frame_end(frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OFF;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (!enable) begin
      state_d = OFF;
    end else begin
      case (state)
        OFF:     state_d = BLANK;
        BLANK:   if (blank_end) state_d = SHOW;
        SHOW:    if (slot_end)  state_d = BLANK;
        default: state_d = OFF;
      endcase
    end
  end

  // Valid/ready: a transfer happens on any edge where load_valid && load_ready; load_ready is simply
  // "pending buffer empty". Commit needs a full buffer and capture an empty one, so the two never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
    end else if (pend_full && (state == OFF || frame_end)) begin
      active    <= pending;
      pend_full <= 1'b0;
    end else if (!pend_full && load_valid) begin
      pending   <= load_data;
      pend_full <= 1'b1;
    end
  end

  assign load_ready = !pend_full;

  assign cur_code = active[idx*DIGIT_W +: DIGIT_W];

  seven_segment_decoder u_dec (
    .code (cur_code),
    .seg_n(cur_seg)
  );

  // enable gates the strobes directly so the display goes dark one cycle after enable drops.
  assign lit = enable && (state == SHOW) && digit_en[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= '1;
      seg_n      <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      an_n       <= lit ? ~(AN_LSB << idx) : '1;
      seg_n      <= lit ? cur_seg : SEG_BLANK;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Directed-plus-random bench for seven_segment_scan_ctrl against a time-based reference model.
module tb_seven_segment_scan_ctrl;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int B  = 2;
  localparam int DW = 3 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [N-1:0]  digit_en;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic [N-1:0]  an_n;
  logic [6:0]    seg_n;
  logic          frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: t counts enabled cycles since scanning started (-1 while dark).
  int            t;
  logic [DW-1:0] m_active, m_pending;
  bit            m_pend;
  logic [N-1:0]  m_an;
  logic [6:0]    m_seg;
  bit            m_ft;
  bit            m_took;
  logic [6:0]    seg_tab [8];

  always #5 clk = ~clk;

  seven_segment_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .digit_en  (digit_en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .frame_tick(frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    t         = -1;
    m_active  = '0;
    m_pending = '0;
    m_pend    = 0;
    m_an      = '1;
    m_seg     = 7'h7f;
    m_ft      = 0;
    m_took    = 0;
  endtask

  function automatic int m_slot();
    return (t / R) % N;
  endfunction

  // Applies the inputs seen at this rising edge to the model.
  task automatic model_edge();
    bit old_pend;
    bit boundary;
    int slot;
    int ph;
    old_pend = m_pend;
    m_took   = 0;
    slot     = (t >= 0) ? (t / R) % N : 0;
    ph       = (t >= 0) ? t % R : 0;
    boundary = enable && (t >= 0) && ((t % (N * R)) == N * R - 1);
    m_ft     = boundary;
    if (enable && t >= 0 && ph >= B && digit_en[slot]) begin
      m_an        = '1;
      m_an[slot]  = 1'b0;
      m_seg       = seg_tab[m_active[3*slot +: 3]];
    end else begin
      m_an  = '1;
      m_seg = 7'h7f;
    end
    if (old_pend && (t < 0 || boundary)) begin
      m_active = m_pending;
      m_pend   = 0;
    end
    if (!old_pend && load_valid) begin
      m_pending = load_data;
      m_pend    = 1;
      m_took    = 1;
    end
    t = enable ? t + 1 : -1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an_n", 32'(an_n), 32'(m_an));
    check("seg_n", 32'(seg_n), 32'(m_seg));
    check("frame_tick", 32'(frame_tick), 32'(m_ft));
    check("load_ready", 32'(load_ready), 32'(!m_pend));
    check("an_onecold", 32'($countones(~an_n) <= 1), 32'(1));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Offers d until accepted; while the pending buffer is full, load_data carries junk.
  task automatic offer(input logic [DW-1:0] d);
    int waited;
    waited     = 0;
    load_valid = 1'b1;
    load_data  = m_pend ? DW'($urandom) : d;
    do begin
      cycle();
      waited++;
      if (!m_took) load_data = m_pend ? DW'($urandom) : d;
    end while (!m_took && waited < 200);
    load_valid = 1'b0;
    load_data  = DW'($urandom);
  endtask

  initial begin
    int guard;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    model_reset();

    // Reset values
    rst_n      = 1'b0;
    enable     = 1'b0;
    digit_en   = '1;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_an_n", 32'(an_n), 32'hf);
    check("rst_seg_n", 32'(seg_n), 32'h7f);
    check("rst_ready", 32'(load_ready), 32'(1));
    check("rst_tick", 32'(frame_tick), 32'(0));
    #2 rst_n = 1'b1;
    run(3);

    // Step 1: enable, load 3210 mid-frame, watch several frames
    enable = 1'b1;
    run(5);
    offer(12'o3210);
    run(3 * N * R);

    // Step 2: back-to-back loads, second one is held off
    run($urandom_range(3, 20));
    offer(DW'($urandom));
    offer(DW'($urandom));
    run(2 * N * R);

    // Step 3: digit 2 disabled, then mid-frame digit_en changes
    digit_en = 4'b1011;
    run(2 * N * R);
    for (int i = 0; i < 8; i++) begin
      digit_en = N'($urandom_range(0, 15));
      run($urandom_range(1, 9));
    end
    digit_en = '1;

    // Step 4: drop enable mid-SHOW of digit 2, then restart
    guard = 0;
    while (!(t >= 0 && m_slot() == 2 && (t % R) == B + 2) && guard < 100) begin
      cycle();
      guard++;
    end
    enable = 1'b0;
    cycle();
    check("dark_an_n", 32'(an_n), 32'hf);
    check("dark_seg_n", 32'(seg_n), 32'h7f);
    run(4);
    offer(DW'($urandom));
    run(2);
    enable = 1'b1;
    run(N * R + 4);

    // Step 5: random soak
    for (int i = 0; i < 600; i++) begin
      enable     = ($urandom_range(0, 39) != 0);
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = DW'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = N'($urandom_range(0, 15));
      cycle();
    end
    load_valid = 1'b0;
    enable     = 1'b1;
    digit_en   = '1;
    run(N * R);

    // Step 6: asynchronous reset mid-slot with a pending frame
    offer(12'o7777);
    run(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an_n", 32'(an_n), 32'hf);
    check("arst_seg_n", 32'(seg_n), 32'h7f);
    check("arst_ready", 32'(load_ready), 32'(1));
    check("arst_tick", 32'(frame_tick), 32'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run(3 * N * R);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
